event_run_sequencer: RTL and testbench

//  Sequences the pulse event counter over one multi-period measurement run: arms it (drives its Reset),

---
 rtl/event_ctrl_pkg.sv | 25 ++
 rtl/event_run_sequencer_if.sv | 39 +++
 rtl/sat_accumulator.sv | 57 +++++
 rtl/event_run_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_event_run_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_ctrl_pkg.sv
// event_ctrl_pkg
//   Shared definitions for the event-counter control family: run-sequencer
//   state encoding, scope output levels for the busy indicator, the length
//   of the counter arming window and default datapath widths.
//   No ports (package).
package event_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DEAD   = 3'd4
  } run_state_t;

  localparam logic signed [15:0] HI_LVL = 16'sh7FFF;
  localparam logic signed [15:0] LO_LVL = 16'sh0000;

  localparam int ARM_CYCLES = 2;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_DT_W  = 16;

endpackage

// File: rtl/event_run_sequencer_if.sv
// event_run_sequencer_if
//   Result record handshake between the run sequencer and its consumer.
//   Signals:
//     ResultValid   record valid (sequencer -> consumer)
//     ResultReady   consumer accepts record (consumer -> sequencer)
//     BrightPeriods periods at or above the bright threshold
//     TotalCount    saturating pulse total of the run
//     Overflow      TotalCount saturated during the run
//   Modports: master = sequencer side, slave = consumer side.
interface event_run_sequencer_if
  import event_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic             ResultValid;
  logic             ResultReady;
  logic [CNT_W-1:0] BrightPeriods;
  logic [ACC_W-1:0] TotalCount;
  logic             Overflow;

  modport master (
    output ResultValid,
    output BrightPeriods,
    output TotalCount,
    output Overflow,
    input  ResultReady
  );

  modport slave (
    input  ResultValid,
    input  BrightPeriods,
    input  TotalCount,
    input  Overflow,
    output ResultReady
  );

endinterface

// File: rtl/sat_accumulator.sv
// sat_accumulator
//   Unsigned accumulator that clamps at its all-ones value and remembers
//   (sticky) that it clamped.
//   Ports:
//     Clk, Reset   clock, synchronous active-high reset
//     clr_i        clear sum and overflow flag (takes priority over en_i)
//     en_i         add addend_i this cycle
//     addend_i     unsigned addend, CNT_W bits (CNT_W <= ACC_W)
//     sum_o        registered saturating sum
//     ovf_o        registered sticky saturation flag
module sat_accumulator
  import event_ctrl_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic [ACC_W:0]   add_res;

  // Returns {saturated, clamped_sum}; one guard bit catches the carry out.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [CNT_W-1:0] add);
    logic [ACC_W:0] wide;
    wide = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, add};
    if (wide[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  assign add_res = sat_add(sum_q, addend_i);

  always_ff @(posedge Clk) begin
    if (Reset || clr_i) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= add_res[ACC_W-1:0];
      ovf_q <= ovf_q | add_res[ACC_W];
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/event_run_sequencer.sv
// event_run_sequencer
//   Runs one multi-period measurement on the pulse event counter: arms the
//   counter, collects per-period counts into run statistics, hands a result
//   record downstream, then idles or re-arms after a dead time.
//   Ports:
//     Clk, Reset      clock, synchronous active-high reset
//     Start           one-cycle run request (IDLE only)
//     Abort           cancel run from any state, highest priority
//     Continuous      re-arm after each accepted result
//     NumPeriods      periods per run (0 -> 1), latched on Start
//     MinPulseCount   bright threshold, latched on Start
//     DeadTime        counter-reset clocks between continuous runs, latched on Start
//     PeriodDone      period-end strobe from the event counter
//     PeriodCount     pulse count of the finishing period
//     CntReset        event counter reset
//     res             result record handshake (master side)
//     Busy            high outside IDLE
//     DataOutA        scope busy level (HI_LVL / LO_LVL)
module event_run_sequencer
  import event_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int DT_W  = DEF_DT_W
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic                      Continuous,
  input  logic [CNT_W-1:0]          NumPeriods,
  input  logic [CNT_W-1:0]          MinPulseCount,
  input  logic [DT_W-1:0]           DeadTime,
  input  logic                      PeriodDone,
  input  logic [CNT_W-1:0]          PeriodCount,
  output logic                      CntReset,
  event_run_sequencer_if.master     res,
  output logic                      Busy,
  output logic signed [15:0]        DataOutA
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);
  localparam logic [1:0]       ARM_LAST = 2'(ARM_CYCLES - 1);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] bright_q, bright_d;
  logic [DT_W-1:0]  dead_q, dead_d;
  logic [1:0]       arm_q, arm_d;
  logic             acc_clr, acc_en;

  logic               valid_q;
  logic               cntrst_q;
  logic               busy_q;
  logic signed [15:0] dout_q;

  logic [ACC_W-1:0] total;
  logic             ovf;

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    min_d    = min_q;
    dt_d     = dt_q;
    idx_d    = idx_q;
    bright_d = bright_q;
    dead_d   = dead_q;
    arm_d    = arm_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_ARM;
          num_d   = (NumPeriods == '0) ? CNT_ONE : NumPeriods;
          min_d   = MinPulseCount;
          dt_d    = DeadTime;
        end
      end
      ST_ARM: begin
        if (arm_q == ARM_LAST) begin
          state_d = ST_RUN;
        end else begin
          arm_d = arm_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (PeriodDone) begin
          acc_en = 1'b1;
          idx_d  = idx_q + CNT_ONE;
          if (PeriodCount >= min_q) begin
            bright_d = bright_q + CNT_ONE;
          end
          if (idx_q + CNT_ONE == num_q) begin
            state_d = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        // ResultValid is high for every REPORT cycle, so Ready alone completes the handshake.
        if (res.ResultReady) begin
          if (!Continuous) begin
            state_d = ST_IDLE;
          end else if (dt_q == '0) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_DEAD;
            dead_d  = DT_ONE;
          end
        end
      end
      ST_DEAD: begin
        if (dead_q == dt_q) begin
          state_d = ST_ARM;
        end else begin
          dead_d = dead_q + DT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; result registers keep whatever they held.
    if (Abort) begin
      state_d  = ST_IDLE;
      num_d    = num_q;
      min_d    = min_q;
      dt_d     = dt_q;
      idx_d    = idx_q;
      bright_d = bright_q;
      acc_en   = 1'b0;
    end

    // Run statistics are cleared only when a fresh arming window begins.
    if (state_d == ST_ARM && state_q != ST_ARM) begin
      arm_d    = '0;
      idx_d    = '0;
      bright_d = '0;
      acc_clr  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      min_q    <= '0;
      dt_q     <= '0;
      idx_q    <= '0;
      bright_q <= '0;
      dead_q   <= '0;
      arm_q    <= '0;
      valid_q  <= 1'b0;
      cntrst_q <= 1'b1;
      busy_q   <= 1'b0;
      dout_q   <= LO_LVL;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      min_q    <= min_d;
      dt_q     <= dt_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      dead_q   <= dead_d;
      arm_q    <= arm_d;
      // Outputs are registered from the next state so they line up with it.
      valid_q  <= (state_d == ST_REPORT);
      cntrst_q <= (state_d != ST_RUN);
      busy_q   <= (state_d != ST_IDLE);
      dout_q   <= (state_d != ST_IDLE) ? HI_LVL : LO_LVL;
    end
  end

  sat_accumulator #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .addend_i (PeriodCount),
    .sum_o    (total),
    .ovf_o    (ovf)
  );

  assign res.ResultValid   = valid_q;
  assign res.BrightPeriods = bright_q;
  assign res.TotalCount    = total;
  assign res.Overflow      = ovf;
  assign CntReset          = cntrst_q;
  assign Busy              = busy_q;
  assign DataOutA          = dout_q;

endmodule

// File: tb/tb_event_run_sequencer.sv
// tb_event_run_sequencer
//   Drives two sequencer instances (32-bit and 17-bit accumulators) from the
//   same stimulus and checks them against a run-level reference model that
//   derives bright periods, totals and saturation from the list of period
//   counts fed in each run.
module tb_event_run_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Abort, Continuous, PeriodDone, ResultReady;
  logic [15:0] NumPeriods, MinPulseCount, DeadTime, PeriodCount;
  logic        cr32, bz32, cr17, bz17;
  logic signed [15:0] do32, do17;

  event_run_sequencer_if #(.CNT_W(16), .ACC_W(32)) if32 ();
  event_run_sequencer_if #(.CNT_W(16), .ACC_W(17)) if17 ();

  assign if32.ResultReady = ResultReady;
  assign if17.ResultReady = ResultReady;

  event_run_sequencer #(.CNT_W(16), .ACC_W(32), .DT_W(16)) dut32 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Continuous(Continuous),
    .NumPeriods(NumPeriods), .MinPulseCount(MinPulseCount), .DeadTime(DeadTime),
    .PeriodDone(PeriodDone), .PeriodCount(PeriodCount), .CntReset(cr32),
    .res(if32), .Busy(bz32), .DataOutA(do32)
  );

  event_run_sequencer #(.CNT_W(16), .ACC_W(17), .DT_W(16)) dut17 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Continuous(Continuous),
    .NumPeriods(NumPeriods), .MinPulseCount(MinPulseCount), .DeadTime(DeadTime),
    .PeriodDone(PeriodDone), .PeriodCount(PeriodCount), .CntReset(cr17),
    .res(if17), .Busy(bz17), .DataOutA(do17)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned pcs[$];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: statistics of the first n period counts of the run.
  function automatic longint unsigned exp_sum(input int n);
    longint unsigned s = 0;
    for (int i = 0; i < n; i++) s += pcs[i];
    return s;
  endfunction

  function automatic logic [63:0] exp_bright(input int n, input int unsigned minc);
    int b = 0;
    for (int i = 0; i < n; i++) if (pcs[i] >= minc) b++;
    return 64'(b);
  endfunction

  function automatic logic [63:0] sat_to(input longint unsigned s, input int w);
    longint unsigned mx = (64'd1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  task automatic check_results(input string tag, input int n, input int unsigned minc);
    longint unsigned s = exp_sum(n);
    chk({tag, "_bright32"}, 64'(if32.BrightPeriods), exp_bright(n, minc));
    chk({tag, "_total32"},  64'(if32.TotalCount), sat_to(s, 32));
    chk({tag, "_ovf32"},    64'(if32.Overflow), 64'(s > 64'hFFFF_FFFF));
    chk({tag, "_bright17"}, 64'(if17.BrightPeriods), exp_bright(n, minc));
    chk({tag, "_total17"},  64'(if17.TotalCount), sat_to(s, 17));
    chk({tag, "_ovf17"},    64'(if17.Overflow), 64'(s > 64'h1_FFFF));
  endtask

  // Cycles after the Start/re-arm edge: two ARM cycles with statistics cleared.
  task automatic arm_checks();
    chk("arm1_cntrst", 64'(cr32), 1);
    chk("arm1_cntrst17", 64'(cr17), 1);
    chk("arm1_busy", 64'(bz32), 1);
    chk("arm1_dout", 64'($unsigned(do32)), 64'h7FFF);
    chk("arm_clr_total", 64'(if32.TotalCount), 0);
    chk("arm_clr_bright", 64'(if32.BrightPeriods), 0);
    chk("arm_clr_ovf17", 64'(if17.Overflow), 0);
    cyc();
    chk("arm2_cntrst", 64'(cr32), 1);
    cyc();
    chk("run_cntrst", 64'(cr32), 0);
  endtask

  task automatic start_run(input int np, input int unsigned minc, input int dt);
    NumPeriods = 16'(np); MinPulseCount = 16'(minc); DeadTime = 16'(dt);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    NumPeriods = 16'($urandom); MinPulseCount = 16'($urandom); DeadTime = 16'($urandom);
    arm_checks();
  endtask

  // Feed pcs[0..n-1]; the strobe at index run_len-1 should end the run.
  task automatic feed(input int n, input int run_len, input bit glitch);
    for (int i = 0; i < n; i++) begin
      if (glitch && i == 0) begin
        Start = 1'b1;
        cyc();
        Start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) cyc();
      PeriodDone = 1'b1;
      PeriodCount = 16'(pcs[i]);
      cyc();
      PeriodDone = 1'b0;
      PeriodCount = 16'($urandom);
      if (i == run_len - 1) begin
        chk("valid_after_last32", 64'(if32.ResultValid), 1);
        chk("valid_after_last17", 64'(if17.ResultValid), 1);
        chk("report_cntrst", 64'(cr32), 1);
      end else begin
        chk("valid_early", 64'(if32.ResultValid), 0);
      end
    end
  endtask

  task automatic handshake(input int wait_cycles);
    ResultReady = 1'b0;
    repeat (wait_cycles) begin
      cyc();
      chk("hold_valid", 64'(if32.ResultValid), 1);
    end
    ResultReady = 1'b1;
    cyc();
    ResultReady = 1'b0;
    chk("hs_valid_low32", 64'(if32.ResultValid), 0);
    chk("hs_valid_low17", 64'(if17.ResultValid), 0);
    chk("hs_busy32", 64'(bz32), 0);
    chk("hs_busy17", 64'(bz17), 0);
  endtask

  initial begin
    int unsigned minc;
    int np, n;

    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Continuous = 1'b0;
    PeriodDone = 1'b0; ResultReady = 1'b0;
    NumPeriods = '0; MinPulseCount = '0; DeadTime = '0; PeriodCount = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_cntrst", 64'(cr32), 1);
    chk("rst_valid", 64'(if32.ResultValid), 0);
    chk("rst_busy", 64'(bz32), 0);
    chk("rst_ovf", 64'(if32.Overflow), 0);
    chk("rst_bright", 64'(if32.BrightPeriods), 0);
    chk("rst_total", 64'(if32.TotalCount), 0);
    chk("rst_dout32", 64'($unsigned(do32)), 0);
    chk("rst_dout17", 64'($unsigned(do17)), 0);
    Reset = 1'b0;
    cyc();
    chk("idle_cntrst", 64'(cr32), 1);
    chk("idle_busy", 64'(bz32), 0);

    // Directed run: 30,10,25,40 against threshold 25
    pcs = '{30, 10, 25, 40};
    start_run(4, 25, 0);
    feed(4, 4, 1'b0);
    chk("t1_bright", 64'(if32.BrightPeriods), 3);
    chk("t1_total", 64'(if32.TotalCount), 105);
    chk("t1_ovf", 64'(if32.Overflow), 0);
    check_results("t1", 4, 25);

    // Consumer stalls for 10 clocks while stray strobes arrive
    ResultReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      PeriodDone = 1'($urandom_range(0, 1));
      PeriodCount = 16'($urandom);
      cyc();
      chk("t2_valid", 64'(if32.ResultValid), 1);
      chk("t2_cntrst", 64'(cr32), 1);
      chk("t2_total", 64'(if32.TotalCount), 105);
      chk("t2_bright", 64'(if32.BrightPeriods), 3);
    end
    PeriodDone = 1'b0;
    handshake(0);
    chk("t2_idle_cntrst", 64'(cr32), 1);
    cyc();
    chk("t2_hold_total", 64'(if32.TotalCount), 105);

    // Continuous mode with 5 clocks of dead time
    Continuous = 1'b1;
    minc = $urandom_range(0, 200);
    pcs.delete();
    for (int i = 0; i < 3; i++) pcs.push_back($urandom_range(0, 400));
    start_run(3, minc, 5);
    feed(3, 3, 1'b0);
    check_results("t3a", 3, minc);
    ResultReady = 1'b1;
    cyc();
    ResultReady = 1'b0;
    chk("t3_valid_low", 64'(if32.ResultValid), 0);
    chk("t3_dead_cntrst1", 64'(cr32), 1);
    for (int k = 2; k <= 7; k++) begin
      cyc();
      chk("t3_dead_cntrst", 64'(cr32), 1);
      if (k == 5) chk("t3_dead_hold_total", 64'(if32.TotalCount), sat_to(exp_sum(3), 32));
      if (k == 6) begin
        chk("t3_rearm_total", 64'(if32.TotalCount), 0);
        chk("t3_rearm_bright", 64'(if32.BrightPeriods), 0);
      end
    end
    cyc();
    chk("t3_run2_cntrst", 64'(cr32), 0);
    pcs.delete();
    for (int i = 0; i < 3; i++) pcs.push_back($urandom_range(0, 400));
    feed(3, 3, 1'b0);
    check_results("t3b", 3, minc);
    Continuous = 1'b0;
    handshake($urandom_range(0, 3));

    // Abort after 2 of 4 periods, then Start together with Abort
    minc = $urandom_range(0, 300);
    pcs.delete();
    for (int i = 0; i < 4; i++) pcs.push_back($urandom_range(0, 600));
    start_run(4, minc, 0);
    feed(2, 4, 1'b0);
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    chk("t4_busy", 64'(bz32), 0);
    chk("t4_valid", 64'(if32.ResultValid), 0);
    chk("t4_cntrst", 64'(cr32), 1);
    chk("t4_dout", 64'($unsigned(do32)), 0);
    check_results("t4_partial", 2, minc);
    for (int k = 0; k < 3; k++) begin
      PeriodDone = 1'b1;
      PeriodCount = 16'($urandom);
      cyc();
      chk("t4_no_result", 64'(if32.ResultValid), 0);
    end
    PeriodDone = 1'b0;
    Start = 1'b1; Abort = 1'b1;
    cyc();
    Start = 1'b0; Abort = 1'b0;
    chk("t4_start_abort_busy", 64'(bz32), 0);
    chk("t4_start_abort_cntrst", 64'(cr32), 1);

    // Saturation in the 17-bit accumulator
    pcs = '{32'hFFFF, 32'hFFFF, 32'hFFFF};
    start_run(3, 32'h100, 0);
    feed(3, 3, 1'b0);
    chk("t5_total17", 64'(if17.TotalCount), 64'h1FFFF);
    chk("t5_ovf17", 64'(if17.Overflow), 1);
    chk("t5_bright17", 64'(if17.BrightPeriods), 3);
    chk("t5_total32", 64'(if32.TotalCount), 64'h2FFFD);
    chk("t5_ovf32", 64'(if32.Overflow), 0);
    handshake(2);

    // NumPeriods = 0 runs one period; Start during RUN is ignored
    minc = $urandom_range(0, 100);
    pcs = '{32'($urandom_range(0, 200))};
    start_run(0, minc, 0);
    feed(1, 1, 1'b1);
    check_results("t6", 1, minc);
    handshake(1);
    cyc();
    chk("t6_stays_idle", 64'(bz32), 0);

    // Reset in the middle of a run
    pcs = '{32'd77, 32'd88};
    start_run(2, 10, 0);
    feed(1, 2, 1'b0);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("midrst_busy", 64'(bz32), 0);
    chk("midrst_total", 64'(if32.TotalCount), 0);
    chk("midrst_bright", 64'(if32.BrightPeriods), 0);
    chk("midrst_cntrst", 64'(cr32), 1);

    // Randomised runs
    for (int r = 0; r < 15; r++) begin
      np = $urandom_range(0, 6);
      n = (np == 0) ? 1 : np;
      minc = $urandom_range(0, 150);
      pcs.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) pcs.push_back($urandom_range(16'hF000, 16'hFFFF));
        else pcs.push_back($urandom_range(0, 200));
      end
      start_run(np, minc, 0);
      feed(n, n, 1'($urandom_range(0, 1)));
      check_results("rnd", n, minc);
      handshake($urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
